// File: rtl/iwdg_wb_master.sv
// Wishbone classic master that configures, starts and periodically refreshes
// the IWDG slave: PR, RLR, KR=CCCC, then a repeating KR=AAAA kick plus ST read.
module iwdg_wb_master #(
  parameter int unsigned GRL         = 3,
  parameter logic [31:0] BASE_ADR    = 32'h0100_0000,
  parameter int unsigned KICK_PERIOD = 1024,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned RETRY_MAX   = 3
) (
  input  logic         clk_m2s,
  input  logic         rst_m2s,
  input  logic         start,
  input  logic         stop,
  input  logic [2:0]   cfg_pr,
  input  logic [11:0]  cfg_rlr,
  output logic [31:0]  adr_m2s,
  output logic [31:0]  dat_m2s,
  output logic [GRL:0] sel_m2s,
  output logic         cyc_m2s,
  output logic         stb_m2s,
  output logic         we_m2s,
  output logic         lok_m2s,
  input  logic [31:0]  dat_s2m,
  input  logic         ack_s2m,
  input  logic         err_s2m,
  input  logic         rty_s2m,
  output logic         running,
  output logic         fault,
  output logic [1:0]   st_q,
  output logic [15:0]  kick_cnt
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned KW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
  localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [KW-1:0] K_LOAD  = KW'(KICK_PERIOD - 1);
  localparam logic [RW-1:0] R_MAX   = RW'(RETRY_MAX);

  typedef enum logic [2:0] {
    IDLE, WR_PR, WR_RLR, WR_KR_START, RD_ST, WAIT, WR_KR_KICK, FAULT
  } state_t;

  state_t         state;
  logic [2:0]     cfg_pr_q;
  logic [11:0]    cfg_rlr_q;
  logic [TW-1:0]  wait_cnt;
  logic [KW-1:0]  kick_tmr;
  logic [RW-1:0]  retry_cnt;
  logic           stop_pend;
  logic           unused_dat;

  assign lok_m2s    = 1'b0;
  assign unused_dat = ^dat_s2m[31:2];

  function automatic logic [31:0] acc_off(input state_t s);
    case (s)
      WR_PR:   acc_off = 32'h4;
      WR_RLR:  acc_off = 32'h8;
      RD_ST:   acc_off = 32'hC;
      default: acc_off = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] acc_dat(input state_t s, input logic [2:0] pr,
                                          input logic [11:0] rlr);
    case (s)
      WR_PR:       acc_dat = {29'b0, pr};
      WR_RLR:      acc_dat = {20'b0, rlr};
      WR_KR_START: acc_dat = 32'h0000_CCCC;
      WR_KR_KICK:  acc_dat = 32'h0000_AAAA;
      default:     acc_dat = '0;
    endcase
  endfunction

  function automatic state_t next_acc(input state_t s);
    case (s)
      WR_PR:       next_acc = WR_RLR;
      WR_RLR:      next_acc = WR_KR_START;
      WR_KR_START: next_acc = RD_ST;
      RD_ST:       next_acc = WAIT;
      default:     next_acc = RD_ST;
    endcase
  endfunction

  // Sequencer, bus driver and status registers in one registered FSM.
  // Entry from IDLE/FAULT/WAIT issues the access on the same edge; after a
  // terminated access the next one issues from the following edge (cyc low
  // in an access state means "gap cycle, issue now"), giving the idle cycle.
  always_ff @(posedge clk_m2s or negedge rst_m2s) begin
    if (!rst_m2s) begin
      state     <= IDLE;
      cfg_pr_q  <= '0;
      cfg_rlr_q <= '0;
      wait_cnt  <= '0;
      kick_tmr  <= '0;
      retry_cnt <= '0;
      stop_pend <= 1'b0;
      adr_m2s   <= '0;
      dat_m2s   <= '0;
      sel_m2s   <= '0;
      cyc_m2s   <= 1'b0;
      stb_m2s   <= 1'b0;
      we_m2s    <= 1'b0;
      running   <= 1'b0;
      fault     <= 1'b0;
      st_q      <= '0;
      kick_cnt  <= '0;
    end else begin
      case (state)
        IDLE, FAULT: begin
          if (start && !stop) begin
            state     <= WR_PR;
            fault     <= 1'b0;
            running   <= 1'b1;
            cfg_pr_q  <= cfg_pr;
            cfg_rlr_q <= cfg_rlr;
            retry_cnt <= '0;
            stop_pend <= 1'b0;
            wait_cnt  <= '0;
            cyc_m2s   <= 1'b1;
            stb_m2s   <= 1'b1;
            sel_m2s   <= '1;
            we_m2s    <= 1'b1;
            adr_m2s   <= BASE_ADR + acc_off(WR_PR);
            dat_m2s   <= acc_dat(WR_PR, cfg_pr, cfg_rlr);
          end
        end
        WAIT: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (kick_tmr == '0) begin
            state    <= WR_KR_KICK;
            wait_cnt <= '0;
            cyc_m2s  <= 1'b1;
            stb_m2s  <= 1'b1;
            sel_m2s  <= '1;
            we_m2s   <= 1'b1;
            adr_m2s  <= BASE_ADR + acc_off(WR_KR_KICK);
            dat_m2s  <= acc_dat(WR_KR_KICK, cfg_pr_q, cfg_rlr_q);
          end else begin
            kick_tmr <= kick_tmr - KW'(1);
          end
        end
        default: begin
          if (!cyc_m2s) begin
            // A stop seen in a gap between completed accesses ends the loop
            // here; inside a retry gap the access still has to complete.
            if ((stop || stop_pend) && retry_cnt == '0) begin
              state     <= IDLE;
              running   <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              if (stop) stop_pend <= 1'b1;
              wait_cnt <= '0;
              cyc_m2s  <= 1'b1;
              stb_m2s  <= 1'b1;
              sel_m2s  <= '1;
              we_m2s   <= (state != RD_ST);
              adr_m2s  <= BASE_ADR + acc_off(state);
              dat_m2s  <= acc_dat(state, cfg_pr_q, cfg_rlr_q);
            end
          end else begin
            if (stop) stop_pend <= 1'b1;
            if (err_s2m || (rty_s2m && retry_cnt == R_MAX) ||
                (!rty_s2m && !ack_s2m && wait_cnt == TO_LAST)) begin
              state     <= FAULT;
              fault     <= 1'b1;
              running   <= 1'b0;
              retry_cnt <= '0;
              stop_pend <= 1'b0;
              cyc_m2s   <= 1'b0;
              stb_m2s   <= 1'b0;
              sel_m2s   <= '0;
              we_m2s    <= 1'b0;
              adr_m2s   <= '0;
              dat_m2s   <= '0;
            end else if (rty_s2m || ack_s2m) begin
              cyc_m2s <= 1'b0;
              stb_m2s <= 1'b0;
              sel_m2s <= '0;
              we_m2s  <= 1'b0;
              adr_m2s <= '0;
              dat_m2s <= '0;
              if (rty_s2m) begin
                retry_cnt <= retry_cnt + RW'(1);
              end else begin
                retry_cnt <= '0;
                if (state == RD_ST)      st_q     <= dat_s2m[1:0];
                if (state == WR_KR_KICK) kick_cnt <= kick_cnt + 16'd1;
                if (stop || stop_pend) begin
                  state     <= IDLE;
                  running   <= 1'b0;
                  stop_pend <= 1'b0;
                end else begin
                  state <= next_acc(state);
                  if (next_acc(state) == WAIT) kick_tmr <= K_LOAD;
                end
              end
            end else begin
              wait_cnt <= wait_cnt + TW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
